// File: rtl/mux_rr_nto1.sv
// mux_rr_nto1: N-to-1 stream multiplexer with a registered output stage.
// One producer channel is granted per cycle, either by an external select
// (mode=0) or by round-robin arbitration over the valid channels (mode=1).
//
// Handshake semantics, used on every channel and on the output:
//   A word moves across an interface at a rising clk edge when valid and ready
//   are both high in the cycle before that edge. A word that is not accepted
//   stays in the producer, and no word is taken without the matching ready.
//   in_ready is combinational and is raised only for the granted channel. It
//   depends on in_valid only through the grant decision.
//   The output register gives out_valid, out_data and out_ch. These stay stable
//   while out_valid && !out_ready.
module mux_rr_nto1 #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // The pointer resets to the last channel, so the first round-robin search
    // starts at channel 0.
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    // Output register and arbitration state
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    // Grant decision
    logic             load_en;
    logic             fx_found;
    logic             rr_hi_found, rr_lo_found;
    logic [SEL_W-1:0] rr_hi_idx,   rr_lo_idx;
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             xfer;

    // The register may take a new word when it is empty or is being drained this cycle
    always_comb begin
        load_en = !out_valid_q || out_ready;
    end

    // Fixed mode: sel picks the channel. An index with no channel never matches
    always_comb begin
        fx_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                fx_found = in_valid[i];
            end
        end
    end

    // Round-robin search: take the lowest valid channel above the pointer,
    // or else wrap to the lowest valid channel overall
    always_comb begin
        rr_hi_found = 1'b0;
        rr_hi_idx   = '0;
        rr_lo_found = 1'b0;
        rr_lo_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                rr_lo_found = 1'b1;
                rr_lo_idx   = SEL_W'(i);
                if (SEL_W'(i) > rr_ptr_q) begin
                    rr_hi_found = 1'b1;
                    rr_hi_idx   = SEL_W'(i);
                end
            end
        end
    end

    // Pick the grant for the active mode (at most one channel)
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (!mode) begin
            gnt_valid = fx_found;
            gnt_idx   = sel;
        end else if (rr_hi_found) begin
            gnt_valid = 1'b1;
            gnt_idx   = rr_hi_idx;
        end else if (rr_lo_found) begin
            gnt_valid = 1'b1;
            gnt_idx   = rr_lo_idx;
        end
    end

    // Drive ready to the granted channel and select its data
    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                in_ready[i] = load_en && gnt_valid;
                gnt_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state: load the granted word, mark the register empty, or hold under backpressure
    always_comb begin
        xfer        = load_en && gnt_valid;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_ch_d    = gnt_idx;
            rr_ptr_d    = gnt_idx;
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and pointer, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= LAST_CH;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
